// File: rtl/opc_intc.sv
// -----------------------------------------------------------------------------
// opc_intc -- vectored interrupt controller for the OPC CPU family.
//
// Takes NCHAN asynchronous requests and applies per-channel mask, edge/level
// mode and fixed priority, where channel 0 is the highest priority. It drives
// the CPU's two active-low int_b lines. The CPU reads the winning vector
// through an eight-word I/O register block at BASE..BASE+7.
//
// Build option: define OPC_INTC_NEST_EN for nested in-service tracking, where
// a higher-priority channel can preempt one that is already in service. With
// the macro undefined the controller is single level: any in-service bit
// blocks every channel until EOI.
//
// Ports:
//   clk, reset_b   clock; asynchronous active-low reset
//   clken          clock enable; state advances only on enabled edges
//   irq_in         asynchronous requests, active high, one per channel
//   vio, rnw       CPU I/O cycle strobe; 1 = read, 0 = write
//   address        CPU word address
//   wdata          write data
//   rdata          combinational read data; 0 unless a hit read is in progress
//   int_b          registered, active low: [1] = channel 0, [0] = channels >= 1
//
// Register map (word offset from BASE):
//   0 PEND    R, write-1-to-clear (edge channels only)
//   1 MASK    RW, 1 = enabled
//   2 MODE    RW, 1 = edge, 0 = level
//   3 VEC     R, acknowledges: [31] valid, [27:20] id, [AW-1:0] vector
//   4 ISR     R, in-service bits
//   5 EOI     W, clears the lowest-index set ISR bit
//   6 STATUS  R, [0] any eligible, [15:8] winning id
//   7         reads 0, writes ignored
//
// Bus: there is no handshake. A read returns data in the same cycle as
// vio/address. Its side effects (the VEC acknowledge) and all writes commit on
// the first clk edge with clken=1 while the access is presented.
// -----------------------------------------------------------------------------
module opc_intc #(
  parameter int unsigned NCHAN      = 8,
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 20,
  parameter int unsigned BASE       = 'hFFF0,
  parameter int unsigned VEC_BASE   = 'h0010,
  parameter int unsigned VEC_STRIDE = 2
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             clken,
  input  logic [NCHAN-1:0] irq_in,
  input  logic             vio,
  input  logic             rnw,
  input  logic [AW-1:0]    address,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic [1:0]       int_b
);

  localparam logic [2:0] R_PEND   = 3'd0;
  localparam logic [2:0] R_MASK   = 3'd1;
  localparam logic [2:0] R_MODE   = 3'd2;
  localparam logic [2:0] R_VEC    = 3'd3;
  localparam logic [2:0] R_ISR    = 3'd4;
  localparam logic [2:0] R_EOI    = 3'd5;
  localparam logic [2:0] R_STATUS = 3'd6;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0] offs;
  logic [2:0]    reg_sel;
  logic          hit;
  logic          wr_en;
  logic          rd_en;

  // The subtraction wraps, so addresses below BASE give large offsets and miss.
  assign offs    = address - AW'(BASE);
  assign hit     = vio && (offs < AW'(8));
  assign reg_sel = offs[2:0];
  assign wr_en   = clken && hit && !rnw;
  assign rd_en   = clken && hit && rnw;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NCHAN-1:0] sync1_q, sync2_q, hist_q;
  logic [NCHAN-1:0] pend_q, pend_d;
  logic [NCHAN-1:0] mask_q, mask_d;
  logic [NCHAN-1:0] mode_q, mode_d;
  logic [NCHAN-1:0] isr_q, isr_d;
  logic [1:0]       int_b_q, int_b_d;

  logic [NCHAN-1:0] wdata_n;
  logic [NCHAN-1:0] edge_det;
  logic [NCHAN-1:0] isr_low;
  logic [NCHAN-1:0] prio_ok;
  logic [NCHAN-1:0] elig;
  logic [NCHAN-1:0] win_oh;
  logic [7:0]       win_id;
  logic             any_elig;
  logic             ack;
  logic             eoi;
  logic [NCHAN-1:0] pend_clr;

  assign wdata_n  = NCHAN'(wdata);
  assign edge_det = sync2_q & ~hist_q;

  // Two's-complement trick: x & -x isolates the lowest set bit.
  assign isr_low = isr_q & (~isr_q + NCHAN'(1));

`ifdef OPC_INTC_NEST_EN
  // Only channels above the one currently in service may compete. When ISR is
  // zero, 0 - 1 wraps to all ones, so every channel may compete.
  assign prio_ok = isr_low - NCHAN'(1);
`else
  // Single level: anything in service blocks every channel until EOI.
  assign prio_ok = (isr_q == '0) ? '1 : '0;
`endif

  assign elig     = pend_q & mask_q & prio_ok;
  assign any_elig = |elig;
  assign win_oh   = elig & (~elig + NCHAN'(1));

  always_comb begin
    win_id = 8'd0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (elig[i]) win_id = 8'(i);
    end
  end

  // A VEC read only acknowledges when a winner exists. Single level needs no
  // extra ISR check because elig is already zero while anything is in service.
  assign ack = rd_en && (reg_sel == R_VEC) && any_elig;
  assign eoi = wr_en && (reg_sel == R_EOI);

  // W1C and acknowledge touch edge channels only.
  assign pend_clr = (((wr_en && reg_sel == R_PEND) ? wdata_n : '0) |
                     (ack ? win_oh : '0)) & mode_q;

  always_comb begin
    // Edge channels: a new edge wins over a same-cycle clear.
    // Level channels: track the synchronised input.
    pend_d = (mode_q & ((pend_q & ~pend_clr) | edge_det)) | (~mode_q & sync2_q);

    mask_d = mask_q;
    if (wr_en && reg_sel == R_MASK) mask_d = wdata_n;

    mode_d = mode_q;
    if (wr_en && reg_sel == R_MODE) mode_d = wdata_n;

    isr_d = isr_q;
    if (ack)      isr_d = isr_q | win_oh;
    else if (eoi) isr_d = isr_q & ~isr_low;

    int_b_d = {~elig[0], ~|(elig & ~NCHAN'(1))};
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '1;
      isr_q   <= '0;
      int_b_q <= 2'b11;
    end else if (clken) begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      isr_q   <= isr_d;
      int_b_q <= int_b_d;
    end
  end

  assign int_b = int_b_q;

  // ---------------------------------------------------------------------------
  // Read mux. The word is built 32 bits wide so the valid flag at bit 31 has a
  // fixed home, then resized to DW.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] vec_addr;
  logic [31:0]   rd_word;

  assign vec_addr = AW'(VEC_BASE) + AW'(win_id) * AW'(VEC_STRIDE);

  always_comb begin
    rd_word = 32'd0;
    case (reg_sel)
      R_PEND: rd_word = 32'(pend_q);
      R_MASK: rd_word = 32'(mask_q);
      R_MODE: rd_word = 32'(mode_q);
      R_VEC: begin
        if (any_elig) begin
          rd_word[AW-1:0] = vec_addr;
          rd_word[27:20]  = win_id;
          rd_word[31]     = 1'b1;
        end
      end
      R_ISR: rd_word = 32'(isr_q);
      R_STATUS: begin
        rd_word[0]    = any_elig;
        rd_word[15:8] = win_id;
      end
      default: rd_word = 32'd0;
    endcase
  end

  assign rdata = (hit && rnw) ? DW'(rd_word) : '0;

endmodule
